ctrl_pipe_chain: RTL and testbench
==================================

# ctrl_pipe_chain

Parametrised control-signal pipeline for the pipelined RISC-V core. It carries a decoded control bundle from Decode through STAGES register boundaries (default Execute, Memory, Writeback) and exposes every stage's bundle. Each stage has its own stall and flush. A downstream stall back-pressures all upstream stages and inserts a bubble behind it. A programmable kill mask guarantees that architecturally visible enables (RegWrite, MemWrite, branch/jump) are zero in any bubble.

## Interface
Parameters:
- STAGES, 3: number of register boundaries (≥1); stage 0 = Execute, stage STAGES-1 = Writeback.
- WIDTH, 16: control bundle width in bits (≥1).
- KILL_MASK, 16'h0007: WIDTH-bit mask of bundle bits forced to 0 in bubbles.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ctrl_in  in  WIDTH  control bundle from the Decode-stage decoders.
- valid_in  in  1  Decode holds a real instruction.
- stall  in  STAGES  stall[i] requests stage i to hold its contents.
- flush  in  STAGES  flush[i] turns stage i into a bubble on the next edge.
- ctrl_out  out  STAGES*WIDTH  stage i bundle at bits [i*WIDTH +: WIDTH].
- valid_out  out  STAGES  stage i holds a real instruction.
- hold_out  out  STAGES  effective hold per stage, used by the datapath registers.

## Operation
- Effective hold: hold[i] = OR of stall[STAGES-1:i], so a stall at stage j also freezes every stage below j. hold_out = hold.
- Next-state per stage i, evaluated in priority order:
  1. flush[i]=1: stage i loads bubble = (src & ~KILL_MASK), valid=0. src is its upstream source: ctrl_in for i=0, stage i-1 otherwise. Flush wins over hold.
  2. hold[i]=1: stage i keeps its bundle and valid.
  3. i>0 and hold[i-1]=1: the upstream stage is frozen, so stage i loads a bubble made from stage i-1's bundle masked by ~KILL_MASK, valid=0. This prevents the upstream instruction from being duplicated.
  4. Otherwise stage i loads src with valid = src valid. For i=0, src valid is valid_in. If valid_in=0, stage 0 stores ctrl_in & ~KILL_MASK.
- Invariant: any stage with valid=0 has all KILL_MASK bits equal to 0. The bench checks this every cycle.
- The block applies no decode. Bundle bit assignment is owned by the controller.

## Timing
- Reset (reset=0, asynchronous): all ctrl_out bits are 0, valid_out=0, and the performance counters are 0. hold_out stays combinational from stall.
- Release is sampled at the first rising edge with reset=1. No bubbles are generated by the release itself.
- Latency: ctrl_in reaches stage k output k+1 cycles after capture, plus one cycle per cycle that stage k or a later stage was held.
- hold_out is combinational from stall, with zero latency. ctrl_out and valid_out are purely registered, with no combinational input-to-output paths.
- Simultaneous events:
  - stall[j] together with flush[j]: stage j becomes a bubble, and stages below j still hold.
  - flush[i] together with hold[i-1]: the bubble rule applies; the result is identical either way.
- Reset asserted mid-stall clears all stages immediately, and stall history is not retained.

## Configuration
- CTRL_PIPE_CHAIN_PERF_EN defined: adds two 32-bit saturating counters, each exposed on an extra output port.
  - perf_retired counts cycles where valid_out[STAGES-1]=1 and hold[STAGES-1]=0.
  - perf_bubbles counts cycles where valid_out[STAGES-1]=0.
  - Both counters clear on reset, stick at 32'hFFFF_FFFF, and cost one register each plus an incrementer.
- Not defined: neither the counters nor the extra ports exist, and the port list is exactly as above.

## Test plan
- Flow, STAGES=3, WIDTH=16: ctrl_in=16'hA5F1, 16'h1234, 16'h00FF with valid_in=1 on consecutive cycles and no stall. Required: stage 2 shows 16'hA5F1 three edges after capture, then 16'h1234, then 16'h00FF, with valid_out=3'b111 in steady state.
- Stall back-pressure: stall=3'b010 for 2 cycles while stage 1 holds 16'h1234.
  - hold_out=3'b011.
  - Stages 0 and 1 are frozen for 2 cycles.
  - Stage 2 gets a bubble with value 16'h1230 and valid_out[2]=0 on each stalled edge.
  - Flow resumes with no instruction lost or duplicated.
- Flush wins: flush[0]=1 and stall[0]=1 with stage 0 = 16'hFFFF. Required: stage 0 becomes 16'hFFF8 with valid_out[0]=0 on the next edge.
- valid_in=0 with ctrl_in=16'h0007. Required: stage 0 = 16'h0000, valid_out[0]=0.
- Async reset asserted mid-cycle during a stall. Required: all outputs are 0 before the next clock edge, and the first edge after release loads ctrl_in normally.
- PERF_EN: 10 valid instructions plus 2 flushes, then drain. Required: perf_retired=10 and perf_bubbles equals the counted bubble cycles. Force the counters near 32'hFFFF_FFFF and check that they saturate.

Source files
------------

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline: carries decoded control from Decode through STAGES registers with per-stage stall/flush.
// Optional performance counters (retired / bubble cycles) are enabled by defining CTRL_PIPE_CHAIN_PERF_EN.
module ctrl_pipe_chain #(
    parameter int STAGES = 3,
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] KILL_MASK = WIDTH'(16'h0007)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          ctrl_in,
    input  logic                      valid_in,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   ctrl_out,
    output logic [STAGES-1:0]         valid_out,
    output logic [STAGES-1:0]         hold_out
`ifdef CTRL_PIPE_CHAIN_PERF_EN
    ,
    output logic [31:0]               perf_retired,
    output logic [31:0]               perf_bubbles
`endif
);

    logic [WIDTH-1:0]  stageCtrl [STAGES];
    logic [WIDTH-1:0]  nextCtrl  [STAGES];
    logic [STAGES-1:0] stageValid;
    logic [STAGES-1:0] nextValid;
    logic [STAGES-1:0] hold;

    // A stall anywhere downstream freezes this stage too.
    always_comb begin
        hold = '0;
        for (int i = 0; i < STAGES; i++) begin
            hold[i] = |(stall >> i);
        end
    end

    assign hold_out = hold;

    // Next-state selection: flush, then hold, then bubble behind a frozen upstream, then normal advance.
    always_comb begin
        nextCtrl  = stageCtrl;
        nextValid = stageValid;
        if (flush[0]) begin
            nextCtrl[0]  = ctrl_in & ~KILL_MASK;
            nextValid[0] = 1'b0;
        end else if (!hold[0]) begin
            nextCtrl[0]  = valid_in ? ctrl_in : (ctrl_in & ~KILL_MASK);
            nextValid[0] = valid_in;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (flush[i] || (!hold[i] && hold[i-1])) begin
                nextCtrl[i]  = stageCtrl[i-1] & ~KILL_MASK;
                nextValid[i] = 1'b0;
            end else if (!hold[i]) begin
                nextCtrl[i]  = stageValid[i-1] ? stageCtrl[i-1] : (stageCtrl[i-1] & ~KILL_MASK);
                nextValid[i] = stageValid[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stageCtrl[i] <= '0;
            end
            stageValid <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stageCtrl[i] <= nextCtrl[i];
            end
            stageValid <= nextValid;
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < STAGES; i++) begin
            ctrl_out[i*WIDTH +: WIDTH] = stageCtrl[i];
        end
    end

    assign valid_out = stageValid;

`ifdef CTRL_PIPE_CHAIN_PERF_EN
    logic [31:0] perfRetired;
    logic [31:0] perfBubbles;
    logic        retireNow;
    logic        bubbleNow;

    assign retireNow = stageValid[STAGES-1] & ~hold[STAGES-1];
    assign bubbleNow = ~stageValid[STAGES-1];

    // Saturating counters observed at the Writeback boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfRetired <= '0;
            perfBubbles <= '0;
        end else begin
            if (retireNow && (perfRetired != 32'hFFFF_FFFF)) begin
                perfRetired <= perfRetired + 32'd1;
            end
            if (bubbleNow && (perfBubbles != 32'hFFFF_FFFF)) begin
                perfBubbles <= perfBubbles + 32'd1;
            end
        end
    end

    assign perf_retired = perfRetired;
    assign perf_bubbles = perfBubbles;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed self-checking bench for ctrl_pipe_chain (STAGES=3, WIDTH=16, KILL_MASK=16'h0007).
// Perf-counter checks compile only when CTRL_PIPE_CHAIN_PERF_EN is defined.
module tb_ctrl_pipe_chain;

    localparam int STAGES = 3;
    localparam int WIDTH = 16;
    localparam logic [15:0] KILL = 16'h0007;

    logic        clk;
    logic        reset;
    logic [15:0] ctrl_in;
    logic        valid_in;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic [47:0] ctrl_out;
    logic [2:0]  valid_out;
    logic [2:0]  hold_out;
`ifdef CTRL_PIPE_CHAIN_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_bubbles;
`endif

    int checksTotal = 0;
    int checksPassed = 0;

    ctrl_pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .KILL_MASK(KILL)) dut (
        .clk(clk),
        .reset(reset),
        .ctrl_in(ctrl_in),
        .valid_in(valid_in),
        .stall(stall),
        .flush(flush),
        .ctrl_out(ctrl_out),
        .valid_out(valid_out),
        .hold_out(hold_out)
`ifdef CTRL_PIPE_CHAIN_PERF_EN
        ,
        .perf_retired(perf_retired),
        .perf_bubbles(perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] c, input logic v, input logic [2:0] s, input logic [2:0] f);
        ctrl_in  = c;
        valid_in = v;
        stall    = s;
        flush    = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bubbles must never carry architecturally visible enables.
    always @(negedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (!valid_out[i]) begin
                checkOutput("killInvariant", 64'(ctrl_out[i*WIDTH +: WIDTH] & KILL), 64'h0);
            end
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(16'h0000, 1'b0, 3'b100, 3'b000);
        #2;
        checkOutput("rstCtrl", 64'(ctrl_out), 64'h0);
        checkOutput("rstValid", 64'(valid_out), 64'h0);
        checkOutput("rstHoldComb", 64'(hold_out), 64'b111);

        #10;
        reset = 1'b1;
        applyStimulus(16'hA5F1, 1'b1, 3'b000, 3'b000);
        tick();
        checkOutput("flowS0", 64'(ctrl_out), {16'h0, 16'h0, 16'hA5F1});
        checkOutput("flowV0", 64'(valid_out), 64'b001);
        applyStimulus(16'h1234, 1'b1, 3'b000, 3'b000);
        tick();
        applyStimulus(16'h00FF, 1'b1, 3'b000, 3'b000);
        tick();
        checkOutput("flowFull", 64'(ctrl_out), {16'hA5F1, 16'h1234, 16'h00FF});
        checkOutput("flowValid", 64'(valid_out), 64'b111);

        applyStimulus(16'hBEEF, 1'b1, 3'b010, 3'b000);
        #1;
        checkOutput("stallHold", 64'(hold_out), 64'b011);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("stallCtrl", 64'(ctrl_out), {16'h1230, 16'h1234, 16'h00FF});
            checkOutput("stallValid", 64'(valid_out), 64'b011);
        end
        applyStimulus(16'hBEEF, 1'b1, 3'b000, 3'b000);
        #1;
        checkOutput("resumeHold", 64'(hold_out), 64'b000);
        tick();
        checkOutput("resumeCtrl", 64'(ctrl_out), {16'h1234, 16'h00FF, 16'hBEEF});
        checkOutput("resumeValid", 64'(valid_out), 64'b111);

        applyStimulus(16'hFFFF, 1'b1, 3'b000, 3'b000);
        tick();
        checkOutput("preFlush", 64'(ctrl_out), {16'h00FF, 16'hBEEF, 16'hFFFF});
        applyStimulus(16'hFFFF, 1'b1, 3'b001, 3'b001);
        #1;
        checkOutput("flushHold", 64'(hold_out), 64'b001);
        tick();
        checkOutput("flushWinsCtrl", 64'(ctrl_out), {16'hBEEF, 16'hFFF8, 16'hFFF8});
        checkOutput("flushWinsValid", 64'(valid_out), 64'b100);

        applyStimulus(16'h0007, 1'b0, 3'b000, 3'b000);
        tick();
        checkOutput("invalidInCtrl", 64'(ctrl_out), {16'hFFF8, 16'hFFF8, 16'h0000});
        checkOutput("invalidInValid", 64'(valid_out), 64'b000);

        applyStimulus(16'h1357, 1'b1, 3'b000, 3'b000);
        tick();
        applyStimulus(16'h2468, 1'b1, 3'b000, 3'b000);
        tick();
        applyStimulus(16'h369C, 1'b1, 3'b000, 3'b000);
        tick();
        checkOutput("refillCtrl", 64'(ctrl_out), {16'h1357, 16'h2468, 16'h369C});
        applyStimulus(16'hABCD, 1'b1, 3'b100, 3'b100);
        tick();
        checkOutput("stallFlushTopCtrl", 64'(ctrl_out), {16'h2468, 16'h2468, 16'h369C});
        checkOutput("stallFlushTopValid", 64'(valid_out), 64'b011);
        applyStimulus(16'hABCD, 1'b1, 3'b000, 3'b000);
        tick();
        checkOutput("afterTopCtrl", 64'(ctrl_out), {16'h2468, 16'h369C, 16'hABCD});
        checkOutput("afterTopValid", 64'(valid_out), 64'b111);

        applyStimulus(16'h5555, 1'b1, 3'b010, 3'b000);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncRstCtrl", 64'(ctrl_out), 64'h0);
        checkOutput("asyncRstValid", 64'(valid_out), 64'h0);
        checkOutput("asyncRstHold", 64'(hold_out), 64'b011);
        tick();
        checkOutput("inRstCtrl", 64'(ctrl_out), 64'h0);
        reset = 1'b1;
        applyStimulus(16'h7777, 1'b1, 3'b000, 3'b000);
        tick();
        checkOutput("releaseCtrl", 64'(ctrl_out), {16'h0, 16'h0, 16'h7777});
        checkOutput("releaseValid", 64'(valid_out), 64'b001);

`ifdef CTRL_PIPE_CHAIN_PERF_EN
        reset = 1'b0;
        applyStimulus(16'h0000, 1'b0, 3'b000, 3'b000);
        #1;
        checkOutput("perfRstRetired", 64'(perf_retired), 64'h0);
        checkOutput("perfRstBubbles", 64'(perf_bubbles), 64'h0);
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(16'(k << 4), 1'b1, 3'b000, ((k == 4) || (k == 8)) ? 3'b001 : 3'b000);
            tick();
        end
        applyStimulus(16'h0000, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        checkOutput("perfRetired", 64'(perf_retired), 64'd10);
        checkOutput("perfBubbles", 64'(perf_bubbles), 64'd5);

        force dut.perfBubbles = 32'hFFFF_FFFE;
        #1;
        release dut.perfBubbles;
        applyStimulus(16'h0010, 1'b1, 3'b000, 3'b000);
        tick();
        tick();
        checkOutput("perfBubblesSat", 64'(perf_bubbles), 64'hFFFF_FFFF);
        tick();
        force dut.perfRetired = 32'hFFFF_FFFE;
        #1;
        release dut.perfRetired;
        tick();
        tick();
        checkOutput("perfRetiredSat", 64'(perf_retired), 64'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
